arcade_input_ctrl: RTL and testbench
====================================

Name: arcade_input_ctrl

Overview:
- Converts MiSTer keyboard events and joystick words into the active-low IN0/IN1 registers consumed by the pacman-family core.
- Applies the screen-orientation remap to the directional controls.
- A single press of Start runs an automatic coin-then-start sequence, because the game accepts Start only after it has registered a credit.
- Sits between hps_io (ps2_key, joystick_0/1, status) and the core's in0_reg/in1_reg inputs.

Parameters:
- COIN_LEN, 2400000: clk_sys cycles coin is asserted (100 ms at 24 MHz).
- GAP_LEN, 4800000: cycles between coin release and start assertion.
- START_LEN, 2400000: cycles start is asserted.
- CNT_W, 23: phase counter width; must hold max(LEN)-1.

Ports:
- clk_sys, input, 1: system clock, 24 MHz.
- RESET, input, 1: synchronous, active-high reset.
- ps2_key, input, 11: [10] toggles once per key event; [9] pressed; [8] extended flag (ignored); [7:0] scan code.
- joy, input, 16: OR of both joysticks. Bit 0 right, 1 left, 2 down, 3 up, 4 start1, 5 start2, 6 coin.
- orient, input, 1: 1 = horizontal (rotated) mode, from status[2].
- in0_reg, output, 8: ~{2'b00, coin, 1'b0, down, right, left, up}.
- in1_reg, output, 8: ~{1'b0, start2, start1, 5'b00000}.
- busy, output, 1: high while the sequencer is not IDLE.

Behaviour:
- **Reset.** While RESET is high at an edge, all of the following are cleared:
  - key latches and the ps2 toggle sample
  - FSM state (to IDLE), phase counter, latched player, start-request history
  - outputs: in0_reg=8'hFF, in1_reg=8'hFF, busy=0
- RESET mid-sequence aborts the sequence immediately; no residual coin or start pulse follows.
- **Key decode.**
  - A new event is taken on an edge where ps2_key[10] differs from its value registered on the previous edge.
  - On that edge, the matched latch is loaded with ps2_key[9].
  - Codes: 75 up, 72 down, 6B left, 74 right, 05 start1 (F1), 06 start2 (F2), 2E direct coin ('5').
  - Other codes are ignored.
- **Orientation** (combinational on latches|joy).
  - orient=0: up=kup|j3, down=kdn|j2, left=klt|j1, right=krt|j0.
  - orient=1: up=klt|j1, down=krt|j0, left=kdn|j2, right=kup|j3.
- **Start requests.** req1 = F1|j4, req2 = F2|j5, req = req1|req2. req is registered each edge for edge detection; rise = req & ~req_q.
- **FSM states.**
  - IDLE: on rise, latch player (2 if req2 else 1; req2 wins when both are high), load counter=0, go to COIN.
  - COIN: seq_coin=1. Counter increments; at count COIN_LEN-1, clear counter and go to GAP. COIN lasts exactly COIN_LEN cycles.
  - GAP: no assertion, GAP_LEN cycles, then START.
  - START: assert the latched player's start for START_LEN cycles, then HOLD.
  - HOLD: no assertion; stay while req=1; go to IDLE on the first edge with req=0. This prevents auto-repeat from a held button.
- rise is ignored outside IDLE.
- busy = (state != IDLE), registered with the outputs.
- **Outputs** are registered; each edge computes:
  - coin = seq_coin | kcoin | j6
  - start1 = (START & player1) | passthrough; start2 = (START & player2) | passthrough
  - Passthrough is raw req1/req2 and is active only while the FSM is in HOLD, so the game also sees a held Start.
  - in0_reg and in1_reg take the inverted vectors.
- **Latency.**
  - Joystick change to output: 1 edge.
  - ps2 event to output: 2 edges (latch, then output register).
  - rise to coin low in in0_reg[5]: 2 edges.
- The counter never wraps: the phase compare resets it at LEN-1.

Test Plan:
- Reset, then release with no input -> in0_reg=8'hFF, in1_reg=8'hFF, busy=0. Assert RESET mid-COIN -> next edge outputs 8'hFF, busy=0.
- orient=0, joy=16'h0008 -> in0_reg=8'hFE after 1 edge. orient=1, same joy -> in0_reg=8'hFB (right).
- ps2_key toggles with {1,0,8'h75} -> in0_reg=8'hFE within 2 edges. Release event {0,0,8'h75} -> 8'hFF. Unknown code 8'h1C -> no change.
- COIN_LEN=4, GAP_LEN=3, START_LEN=5; joy[4] held -> in0_reg[5]=0 for exactly 4 cycles, high for 3, then in1_reg[5]=0 for 5 cycles, then stays 0 through HOLD until joy[4]=0. A second press in GAP is ignored.
- Short params; joy[4] and joy[5] rise on the same edge -> sequence asserts in1_reg[6]=0 (start2); in1_reg[5] stays 1 during START.
- Key '5' pressed during GAP -> in0_reg[5]=0 while held, independent of FSM; the sequence timing is unchanged.

Source files
------------

// File: rtl/arcade_input_ctrl_if.sv
// Host-side bundle between hps_io and the arcade input controller.
// Carries keyboard/joystick/status inputs and the IN0/IN1 results.
interface arcade_input_ctrl_if;
    logic [10:0] ps2_key;
    logic [15:0] joy;
    logic        orient;
    logic [7:0]  in0_reg;
    logic [7:0]  in1_reg;
    logic        busy;

    modport master (
        output ps2_key, joy, orient,
        input  in0_reg, in1_reg, busy
    );

    modport slave (
        input  ps2_key, joy, orient,
        output in0_reg, in1_reg, busy
    );
endinterface

// File: rtl/arcade_input_ctrl.sv
// Keyboard/joystick to active-low IN0/IN1 for the pacman-family core,
// with orientation remap and an automatic coin-then-start sequencer.
module arcade_input_ctrl #(
    parameter int COIN_LEN  = 2400000,
    parameter int GAP_LEN   = 4800000,
    parameter int START_LEN = 2400000,
    parameter int CNT_W     = 23
) (
    input  logic                clk_sys,
    input  logic                RESET,
    arcade_input_ctrl_if.slave  io
);

    typedef enum logic [2:0] {
        IDLE,
        COIN,
        GAP,
        START,
        HOLD
    } state_t;

    localparam int K_UP = 0;
    localparam int K_DN = 1;
    localparam int K_LT = 2;
    localparam int K_RT = 3;
    localparam int K_S1 = 4;
    localparam int K_S2 = 5;
    localparam int K_CN = 6;

    localparam logic [CNT_W-1:0] COIN_LAST  = CNT_W'(COIN_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_LEN - 1);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_LEN - 1);

    logic [6:0]       key_q, key_d;
    logic             tog_q;
    logic             req_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             p2_q, p2_d;
    logic [7:0]       in0_q, in0_d;
    logic [7:0]       in1_q, in1_d;
    logic             busy_q;

    logic new_evt;
    logic up, dn, lt, rt;
    logic req1, req2, req, rise;
    logic coin, start1, start2;
    logic unused_bits;

    assign unused_bits = ^{io.ps2_key[8], io.joy[15:7]};

    assign new_evt = io.ps2_key[10] ^ tog_q;

    assign req1 = key_q[K_S1] | io.joy[4];
    assign req2 = key_q[K_S2] | io.joy[5];
    assign req  = req1 | req2;
    assign rise = req & ~req_q;

    // Key latches follow press/release events for the recognised codes
    always_comb begin
        key_d = key_q;
        if (new_evt) begin
            case (io.ps2_key[7:0])
                8'h75:   key_d[K_UP] = io.ps2_key[9];
                8'h72:   key_d[K_DN] = io.ps2_key[9];
                8'h6B:   key_d[K_LT] = io.ps2_key[9];
                8'h74:   key_d[K_RT] = io.ps2_key[9];
                8'h05:   key_d[K_S1] = io.ps2_key[9];
                8'h06:   key_d[K_S2] = io.ps2_key[9];
                8'h2E:   key_d[K_CN] = io.ps2_key[9];
                default: key_d = key_q;
            endcase
        end
    end

    // Screen orientation remap of the merged directional controls
    always_comb begin
        up = key_q[K_UP] | io.joy[3];
        dn = key_q[K_DN] | io.joy[2];
        lt = key_q[K_LT] | io.joy[1];
        rt = key_q[K_RT] | io.joy[0];
        if (io.orient) begin
            up = key_q[K_LT] | io.joy[1];
            dn = key_q[K_RT] | io.joy[0];
            lt = key_q[K_DN] | io.joy[2];
            rt = key_q[K_UP] | io.joy[3];
        end
    end

    // Sequencer next state: coin, gap, start, then hold until release
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p2_d    = p2_q;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    p2_d    = req2;
                    cnt_d   = '0;
                    state_d = COIN;
                end
            end
            COIN: begin
                if (cnt_q == COIN_LAST) begin
                    cnt_d   = '0;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = START;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            START: begin
                if (cnt_q == START_LAST) begin
                    cnt_d   = '0;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (!req) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output vectors; held Start passes through only once in HOLD
    always_comb begin
        coin   = (state_q == COIN) | key_q[K_CN] | io.joy[6];
        start1 = ((state_q == START) & ~p2_q) |
                 ((state_q == HOLD) & req1);
        start2 = ((state_q == START) & p2_q) |
                 ((state_q == HOLD) & req2);
        in0_d  = ~{2'b00, coin, 1'b0, dn, rt, lt, up};
        in1_d  = ~{1'b0, start2, start1, 5'b00000};
    end

    // State, latches and registered outputs
    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            key_q   <= '0;
            tog_q   <= 1'b0;
            req_q   <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
            p2_q    <= 1'b0;
            in0_q   <= 8'hFF;
            in1_q   <= 8'hFF;
            busy_q  <= 1'b0;
        end else begin
            key_q   <= key_d;
            tog_q   <= io.ps2_key[10];
            req_q   <= req;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p2_q    <= p2_d;
            in0_q   <= in0_d;
            in1_q   <= in1_d;
            busy_q  <= (state_q != IDLE);
        end
    end

    assign io.in0_reg = in0_q;
    assign io.in1_reg = in1_q;
    assign io.busy    = busy_q;

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Directed bench for arcade_input_ctrl with short sequencer phases.
// A time-based reference model is compared every cycle.
module tb_arcade_input_ctrl;

    localparam int C = 4;
    localparam int G = 3;
    localparam int S = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tog = 1'b0;
    int   checks = 0;
    int   failures = 0;

    arcade_input_ctrl_if bus ();

    arcade_input_ctrl #(
        .COIN_LEN (C),
        .GAP_LEN  (G),
        .START_LEN(S),
        .CNT_W    (4)
    ) dut (
        .clk_sys(clk),
        .RESET  (rst),
        .io     (bus)
    );

    always #5 clk = ~clk;

    // Reference model: latched key set, and the sequence as elapsed time
    logic [6:0] mk;
    logic       mtog, mprev, mact, mp2;
    int         mt;
    logic [7:0] e_in0, e_in1;
    logic       e_busy;

    function automatic int key_idx(input logic [7:0] code);
        case (code)
            8'h75: return 0;
            8'h72: return 1;
            8'h6B: return 2;
            8'h74: return 3;
            8'h05: return 4;
            8'h06: return 5;
            8'h2E: return 6;
            default: return -1;
        endcase
    endfunction

    always @(posedge clk) begin
        logic [3:0] lg;
        logic up, dn, lt, rt, r1, r2, rq, cn, s1, s2;
        int ph, ki;
        if (rst) begin
            mk = '0; mtog = 0; mprev = 0; mact = 0; mt = 0; mp2 = 0;
            e_in0 = 8'hFF; e_in1 = 8'hFF; e_busy = 0;
        end else begin
            lg[0] = mk[0] | bus.joy[3];
            lg[1] = mk[1] | bus.joy[2];
            lg[2] = mk[2] | bus.joy[1];
            lg[3] = mk[3] | bus.joy[0];
            if (!bus.orient) {up, dn, lt, rt} = {lg[0], lg[1], lg[2], lg[3]};
            else             {up, dn, lt, rt} = {lg[2], lg[3], lg[1], lg[0]};
            r1 = mk[4] | bus.joy[4];
            r2 = mk[5] | bus.joy[5];
            rq = r1 | r2;
            if (!mact)              ph = 0;
            else if (mt < C)         ph = 1;
            else if (mt < C + G)     ph = 2;
            else if (mt < C + G + S) ph = 3;
            else                     ph = 4;
            cn = (ph == 1) | mk[6] | bus.joy[6];
            s1 = (ph == 3 && !mp2) || (ph == 4 && r1);
            s2 = (ph == 3 && mp2) || (ph == 4 && r2);
            e_in0 = ~{2'b00, cn, 1'b0, dn, rt, lt, up};
            e_in1 = ~{1'b0, s2, s1, 5'b00000};
            e_busy = mact;
            if (mact) begin
                if (ph == 4) begin
                    if (!rq) mact = 0;
                end else begin
                    mt = mt + 1;
                end
            end else if (rq && !mprev) begin
                mact = 1; mt = 0; mp2 = r2;
            end
            mprev = rq;
            if (bus.ps2_key[10] != mtog) begin
                ki = key_idx(bus.ps2_key[7:0]);
                if (ki >= 0) mk[ki] = bus.ps2_key[9];
            end
            mtog = bus.ps2_key[10];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        checks++;
        if ({bus.in0_reg, bus.in1_reg, bus.busy} !== {e_in0, e_in1, e_busy}) begin
            failures++;
            $display("FAIL model t=%0t got in0=%h in1=%h busy=%b want in0=%h in1=%h busy=%b",
                     $time, bus.in0_reg, bus.in1_reg, bus.busy, e_in0, e_in1, e_busy);
        end
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, exp);
        end
    endtask

    task automatic send_key(input logic pressed, input logic [7:0] code);
        tog = ~tog;
        bus.ps2_key = {tog, pressed, 1'b0, code};
    endtask

    initial begin
        bus.ps2_key = '0;
        bus.joy = '0;
        bus.orient = 1'b0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick(); tick();
        chk("rst_in0", bus.in0_reg, 8'hFF);
        chk("rst_in1", bus.in1_reg, 8'hFF);
        chk("rst_busy", {7'd0, bus.busy}, 8'h00);

        bus.joy = 16'h0008;
        tick();
        chk("joy_up", bus.in0_reg, 8'hFE);
        bus.orient = 1'b1;
        tick();
        chk("joy_up_rot", bus.in0_reg, 8'hFB);
        bus.orient = 1'b0;
        bus.joy = '0;
        tick();
        chk("joy_idle", bus.in0_reg, 8'hFF);

        send_key(1'b1, 8'h75);
        tick(); tick();
        chk("key_up", bus.in0_reg, 8'hFE);
        send_key(1'b0, 8'h75);
        tick(); tick();
        chk("key_up_rel", bus.in0_reg, 8'hFF);
        send_key(1'b1, 8'h1C);
        tick(); tick();
        chk("key_unknown", bus.in0_reg, 8'hFF);

        bus.joy = 16'h0010;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("seq_in0", bus.in0_reg, (k >= 2 && k <= 5) ? 8'hDF : 8'hFF);
            chk("seq_in1", bus.in1_reg, (k >= 9) ? 8'hDF : 8'hFF);
            chk("seq_busy", {7'd0, bus.busy}, (k >= 2) ? 8'h01 : 8'h00);
            if (k == 5) bus.joy = 16'h0000;
            if (k == 6) bus.joy = 16'h0010;
        end
        bus.joy = '0;
        tick();
        chk("hold_rel_in1", bus.in1_reg, 8'hFF);
        chk("hold_rel_busy", {7'd0, bus.busy}, 8'h01);
        tick();
        chk("idle_busy", {7'd0, bus.busy}, 8'h00);

        bus.joy = 16'h0030;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (k == 9)  chk("both_start", bus.in1_reg, 8'hBF);
            if (k == 14) chk("both_hold", bus.in1_reg, 8'h9F);
        end
        bus.joy = '0;
        tick(); tick();
        chk("both_idle", {7'd0, bus.busy}, 8'h00);

        bus.joy = 16'h0010;
        for (int k = 1; k <= 15; k++) begin
            tick();
            chk("k5_in0", bus.in0_reg,
                ((k >= 2 && k <= 5) || k == 8 || k == 9) ? 8'hDF : 8'hFF);
            chk("k5_in1", bus.in1_reg, (k >= 9 && k <= 13) ? 8'hDF : 8'hFF);
            if (k == 1) bus.joy = '0;
            if (k == 6) send_key(1'b1, 8'h2E);
            if (k == 8) send_key(1'b0, 8'h2E);
        end
        chk("k5_idle", {7'd0, bus.busy}, 8'h00);

        bus.joy = 16'h0010;
        tick(); tick();
        chk("mid_coin", bus.in0_reg, 8'hDF);
        rst = 1'b1;
        tick();
        chk("mid_rst_in0", bus.in0_reg, 8'hFF);
        chk("mid_rst_in1", bus.in1_reg, 8'hFF);
        chk("mid_rst_busy", {7'd0, bus.busy}, 8'h00);
        bus.joy = '0;
        rst = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            tick();
            chk("post_rst_in0", bus.in0_reg, 8'hFF);
            chk("post_rst_in1", bus.in1_reg, 8'hFF);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
